systolic_drain: RTL and testbench
=================================

# systolic_drain

Output collector for the systolic matrix-multiply array. It captures the per-row result beats (`D[i]` qualified by `valid_D[i]`) that leave the right edge of the array. It reorders each row's column-reversed, row-skewed beats into a double-banked tile buffer. It then streams the completed N1×N2 tile row-major over a ready/valid interface toward the write-back DMA. The array cannot stall, so the two banks absorb one tile of downstream backpressure; anything beyond that is flagged, not blocked.

## Interface
- `D_W_ACC`, default 32: result/accumulator width.
- `N1`, default 8: array rows (tile rows).
- `N2`, default 4: array columns (beats per row per tile).
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `D`  in  signed [D_W_ACC-1:0] x N1: per-row result from the array.
- `valid_D`  in  N1: per-row beat qualifier.
- `m_data`  out  D_W_ACC: streamed result element.
- `m_valid`  out  1: `m_data` valid.
- `m_ready`  in  1: downstream accept.
- `m_row`  out  $clog2(N1) (min 1): row index of current element.
- `m_col`  out  $clog2(N2) (min 1): column index of current element.
- `m_last`  out  1: final element of tile (row N1-1, col N2-1).
- `overflow`  out  1: sticky; a beat was dropped because its bank was full.
- `busy`  out  1: partial tile captured, any bank full, or streaming.

## Operation
- Storage: 2 banks × N1 rows × N2 columns of D_W_ACC.
- Per row i: write counter `wcnt[i]` (0..N2-1), write-bank pointer `wbank[i]`, full flags `full[b][i]`.
- Beat order is fixed: the k-th valid beat of a tile on row i is column N2-1-k.
- Capture: if `valid_D[i]` and `!full[wbank[i]][i]`, write `D[i]` to `[wbank[i]][i][N2-1-wcnt[i]]` and increment `wcnt[i]`. At `wcnt[i]==N2-1`, wrap `wcnt[i]` to 0, set `full[wbank[i]][i]`, and toggle `wbank[i]`.
- Overflow: if `valid_D[i]` and the target bank is full, drop the beat, leave counters unchanged, and set `overflow`. Only `rst` clears `overflow`.
- Reader FSM state IDLE:
  - Hold `m_valid=0`.
  - When `full[rbank][i]` is set for all i, go to STREAM with `r=0`, `c=0`.
- Reader FSM state STREAM:
  - Drive `m_valid=1`, `m_data=mem[rbank][r][c]`, `m_row=r`, `m_col=c`, `m_last=(r==N1-1 && c==N2-1)`.
  - On `m_valid && m_ready`, advance c; on c wrap, advance r.
  - On the last handshake: clear `full[rbank][*]`, toggle `rbank`, return to IDLE.
- Release vs. write in the same cycle: release takes effect first. A beat targeting a bank that is being released in that cycle is accepted, not counted as overflow.
- Rows fill independently. Skew between rows and gaps within a row are arbitrary.
- `m_data`, `m_row`, `m_col` and `m_last` are stable while `m_valid && !m_ready`.
- Reset values:
  - Outputs: `m_valid=0`, `m_last=0`, `m_row=0`, `m_col=0`, `m_data=0`, `overflow=0`, `busy=0`.
  - Internal: all `wcnt`, `wbank`, `rbank` and full flags are 0; FSM in IDLE.
- Reset mid-operation discards partial and full tiles. Bank contents need not be cleared.

## Timing
- Capture is 1 cycle: a beat presented in cycle T is stored, and its full flag updated, at the end of T.
- Tile latency: `m_valid` rises 2 cycles after the cycle carrying the last row's final beat (flag set end of T, IDLE→STREAM end of T+1, `m_valid` high in T+2).
- Throughput: 1 element/cycle with `m_ready` held high; N1·N2 cycles per tile.
- IDLE costs 1 cycle between back-to-back tiles: `m_valid` is low for one cycle after `m_last`.
- Sustained input rate without overflow with `m_ready=1`: one tile per N1·N2+1 cycles.

## Test plan
- Single tile, N1=8, N2=4, `m_ready=1`:
  - Stimulus: row i presents 4 consecutive beats `100*i+3`, `100*i+2`, `100*i+1`, `100*i`, with row i starting i cycles after row 0.
  - Required: 32 beats, with `m_data=100*r+c` in row-major order and `m_last` only on beat 32 (value 703).
  - Required: `m_valid` first high 2 cycles after row 7's last beat; `overflow=0`.
- Backpressure: same tile with `m_ready` toggling 1,0,1,0 → identical sequence; outputs stable during every `m_ready=0` cycle; 63 cycles from first `m_valid` to `m_last` handshake.
- Two back-to-back tiles with `m_ready=1` → 64 beats, `m_last` on beats 32 and 64, one idle cycle between tiles, `overflow=0`.
- Overflow: `m_ready=0`, three tiles presented → tiles 1 and 2 captured, every tile-3 beat dropped, `overflow=1`. Raising `m_ready` then yields exactly tiles 1 and 2 intact; `overflow` stays 1.
- Irregular arrival: random gaps within rows and row skew up to 10 cycles → the same row-major values as the single-tile case.
- Reset mid-stream: assert `rst` during beat 10 of a tile → next cycle `m_valid=0`, `busy=0`, `overflow=0`. A fresh tile afterward streams correctly from row 0, col 0.

Source files
------------

// File: rtl/systolic_drain.sv
// Output collector for the systolic array: reorders column-reversed, row-skewed
// result beats into a 2-bank tile buffer and streams each full tile row-major.
// Latency: capture 1 cycle; m_valid rises 2 cycles after the last beat of a tile.
// Backpressure: m_ready stalls the reader only; the array cannot stall, so a beat
// aimed at a full bank is dropped and the sticky overflow flag is raised.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   D[N1], valid_D    per-row result beats from the array's right edge
//   m_data/m_valid/m_ready  row-major element stream toward write-back DMA
//   m_row, m_col      coordinates of the element on m_data
//   m_last            final element of the tile (row N1-1, col N2-1)
//   overflow          sticky: a beat was dropped because its bank was full
//   busy              partial tile captured, any bank full, or streaming
module systolic_drain #(
  parameter int D_W_ACC = 32,
  parameter int N1      = 8,
  parameter int N2      = 4,
  localparam int RW     = (N1 > 1) ? $clog2(N1) : 1,
  localparam int CW     = (N2 > 1) ? $clog2(N2) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [N1-1:0][D_W_ACC-1:0] D,
  input  logic        [N1-1:0]              valid_D,
  output logic        [D_W_ACC-1:0]         m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic        [RW-1:0]              m_row,
  output logic        [CW-1:0]              m_col,
  output logic                              m_last,
  output logic                              overflow,
  output logic                              busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  // Tile storage: [bank][row][col]. Not reset; full flags define validity.
  logic [D_W_ACC-1:0] mem_q [2][N1][N2];

  logic [N1-1:0][CW-1:0] wcnt_q, wcnt_d;
  logic [N1-1:0]         wbank_q, wbank_d;
  logic [1:0][N1-1:0]    full_q, full_d;
  logic [N1-1:0]         wr_en;
  logic                  ovf_q, ovf_d;

  state_t                state_q, state_d;
  logic                  rbank_q, rbank_d;
  logic [RW-1:0]         r_q, r_d;
  logic [CW-1:0]         c_q, c_d;
  logic                  last_elem;
  logic                  release_bank;

  assign last_elem    = (r_q == RW'(N1 - 1)) && (c_q == CW'(N2 - 1));
  assign release_bank = (state_q == STREAM) && m_ready && last_elem;

  // Writer: per-row counters and full flags. The release of the streamed bank
  // is applied before the capture test so a beat landing in the same cycle
  // sees the bank as free.
  always_comb begin
    full_d  = full_q;
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    ovf_d   = ovf_q;
    wr_en   = '0;
    if (release_bank) begin
      full_d[rbank_q] = '0;
    end
    for (int i = 0; i < N1; i++) begin
      if (valid_D[i]) begin
        if (!full_d[wbank_q[i]][i]) begin
          wr_en[i] = 1'b1;
          if (wcnt_q[i] == CW'(N2 - 1)) begin
            wcnt_d[i]              = '0;
            full_d[wbank_q[i]][i]  = 1'b1;
            wbank_d[i]             = ~wbank_q[i];
          end else begin
            wcnt_d[i] = wcnt_q[i] + 1'b1;
          end
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  // Beats arrive highest column first, so the k-th beat lands in column N2-1-k.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N1; i++) begin
      if (wr_en[i]) begin
        mem_q[wbank_q[i]][i][CW'(N2 - 1) - wcnt_q[i]] <= D[i];
      end
    end
  end

  // Reader FSM next-state.
  always_comb begin
    state_d = state_q;
    rbank_d = rbank_q;
    r_d     = r_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (&full_q[rbank_q]) begin
          state_d = STREAM;
          r_d     = '0;
          c_d     = '0;
        end
      end
      STREAM: begin
        if (m_ready) begin
          if (c_q == CW'(N2 - 1)) begin
            c_d = '0;
            if (r_q == RW'(N1 - 1)) begin
              r_d     = '0;
              state_d = IDLE;
              rbank_d = ~rbank_q;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rbank_q <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
      wcnt_q  <= '0;
      wbank_q <= '0;
      full_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rbank_q <= rbank_d;
      r_q     <= r_d;
      c_q     <= c_d;
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  // The streamed bank is full on every row, so no writer can touch it until
  // release; outputs therefore hold steady while stalled.
  assign m_valid  = (state_q == STREAM);
  assign m_data   = m_valid ? mem_q[rbank_q][r_q][c_q] : '0;
  assign m_row    = r_q;
  assign m_col    = c_q;
  assign m_last   = m_valid && last_elem;
  assign overflow = ovf_q;
  assign busy     = m_valid || (|full_q) || (|wcnt_q);

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;
  localparam int DW = 32;
  localparam int N1 = 8;
  localparam int N2 = 4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic signed [N1-1:0][DW-1:0] D;
  logic        [N1-1:0]         valid_D;
  logic        [DW-1:0]         m_data;
  logic                         m_valid;
  logic                         m_ready;
  logic        [2:0]            m_row;
  logic        [1:0]            m_col;
  logic                         m_last;
  logic                         overflow;
  logic                         busy;

  always #5 clk = ~clk;

  systolic_drain #(.D_W_ACC(DW), .N1(N1), .N2(N2)) dut (
    .clk(clk), .rst(rst), .D(D), .valid_D(valid_D),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_row(m_row), .m_col(m_col), .m_last(m_last),
    .overflow(overflow), .busy(busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] row;
    logic [31:0] col;
    logic        last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];
  beat_t stall_q[$];
  int    stall_idx[$];
  int    sched[3][N1][N2];
  int    ntiles;
  int    tile_base[3] = '{0, 1000, 2000};
  int    first_valid;
  bit    timed_out;
  logic  ov_at_ready;
  logic  ov_end;

  task automatic clear_sched();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < N1; i++)
        for (int k = 0; k < N2; k++) sched[j][i][k] = -1;
    ntiles = 0;
    exp_q.delete();
  endtask

  task automatic add_exp_tile(input int base);
    beat_t b;
    for (int r = 0; r < N1; r++)
      for (int c = 0; c < N2; c++) begin
        b.data = 32'(base + 100 * r + c);
        b.row  = 32'(r);
        b.col  = 32'(c);
        b.last = (r == N1 - 1) && (c == N2 - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_D = '0; D = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle engine: at each negedge it samples outputs, chooses m_ready, logs
  // handshakes and stalled cycles, then drives the scheduled beats.
  task automatic run(input int n_exp, input int ready_on, input bit toggle,
                     input int extra, input int max_cyc);
    int    done_at;
    beat_t b;
    obs_q.delete(); obs_cyc.delete(); stall_q.delete(); stall_idx.delete();
    first_valid = -1; timed_out = 1'b0; done_at = -1; ov_at_ready = 1'bx;
    for (int t = 0; t < max_cyc; t++) begin
      @(negedge clk);
      if (m_valid && first_valid < 0) first_valid = t;
      if (toggle) m_ready = (first_valid < 0) ? 1'b1 : ((t - first_valid) % 2 == 0);
      else        m_ready = (t >= ready_on);
      if (t == ready_on) ov_at_ready = overflow;
      if (m_valid) begin
        b.data = m_data; b.row = 32'(m_row); b.col = 32'(m_col); b.last = m_last;
        if (m_ready) begin
          obs_q.push_back(b); obs_cyc.push_back(t);
        end else begin
          stall_q.push_back(b); stall_idx.push_back(obs_q.size());
        end
      end
      valid_D = '0; D = '0;
      for (int j = 0; j < ntiles; j++)
        for (int i = 0; i < N1; i++)
          for (int k = 0; k < N2; k++)
            if (sched[j][i][k] == t) begin
              valid_D[i] = 1'b1;
              D[i] = DW'(tile_base[j] + 100 * i + (N2 - 1 - k));
            end
      if (done_at < 0 && obs_q.size() >= n_exp) done_at = t;
      if (done_at >= 0 && t >= done_at + extra) break;
    end
    if (done_at < 0) timed_out = 1'b1;
    ov_end = overflow;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_valid  !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last   !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (m_row    !== 3'd0) begin errors++; $display("FAIL reset_m_row: got %0d want 0", m_row); end
    checks++; if (m_col    !== 2'd0) begin errors++; $display("FAIL reset_m_col: got %0d want 0", m_col); end
    checks++; if (m_data   !== 32'd0) begin errors++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (busy     !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_tile();
    do_reset(); clear_sched(); ntiles = 1;
    for (int i = 0; i < N1; i++) for (int k = 0; k < N2; k++) sched[0][i][k] = i + k;
    add_exp_tile(0);
    run(32, 0, 1'b0, 5, 200);
    checks++; if (timed_out) begin errors++; $display("FAIL single_timeout: got %0d beats want 32", obs_q.size()); end
    checks++; if (obs_q.size() != 32) begin errors++; $display("FAIL single_count: got %0d want 32", obs_q.size()); end
    for (int b = 0; b < obs_q.size() && b < exp_q.size(); b++) begin
      checks++;
      if (obs_q[b].data !== exp_q[b].data || obs_q[b].row !== exp_q[b].row ||
          obs_q[b].col !== exp_q[b].col || obs_q[b].last !== exp_q[b].last) begin
        errors++;
        $display("FAIL single_beat %0d: got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", b,
                 obs_q[b].data, obs_q[b].row, obs_q[b].col, obs_q[b].last,
                 exp_q[b].data, exp_q[b].row, exp_q[b].col, exp_q[b].last);
      end
    end
    checks++; if (first_valid != 12) begin errors++; $display("FAIL single_latency: got first m_valid cycle %0d want 12", first_valid); end
    checks++; if (ov_end !== 1'b0) begin errors++; $display("FAIL single_overflow: got %b want 0", ov_end); end
  endtask

  task automatic test_backpressure();
    do_reset(); clear_sched(); ntiles = 1;
    for (int i = 0; i < N1; i++) for (int k = 0; k < N2; k++) sched[0][i][k] = i + k;
    add_exp_tile(0);
    run(32, 0, 1'b1, 5, 300);
    checks++; if (obs_q.size() != 32) begin errors++; $display("FAIL bp_count: got %0d want 32", obs_q.size()); end
    for (int b = 0; b < obs_q.size() && b < exp_q.size(); b++) begin
      checks++;
      if (obs_q[b].data !== exp_q[b].data || obs_q[b].row !== exp_q[b].row ||
          obs_q[b].col !== exp_q[b].col || obs_q[b].last !== exp_q[b].last) begin
        errors++;
        $display("FAIL bp_beat %0d: got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", b,
                 obs_q[b].data, obs_q[b].row, obs_q[b].col, obs_q[b].last,
                 exp_q[b].data, exp_q[b].row, exp_q[b].col, exp_q[b].last);
      end
    end
    checks++; if (stall_q.size() != 31) begin errors++; $display("FAIL bp_stall_count: got %0d want 31", stall_q.size()); end
    for (int s = 0; s < stall_q.size(); s++) begin
      checks++;
      if (stall_idx[s] >= exp_q.size() || stall_q[s].data !== exp_q[stall_idx[s]].data ||
          stall_q[s].row !== exp_q[stall_idx[s]].row || stall_q[s].col !== exp_q[stall_idx[s]].col ||
          stall_q[s].last !== exp_q[stall_idx[s]].last) begin
        errors++;
        $display("FAIL bp_stable stall %0d: got d=%0d r=%0d c=%0d l=%b for pending beat %0d", s,
                 stall_q[s].data, stall_q[s].row, stall_q[s].col, stall_q[s].last, stall_idx[s]);
      end
    end
    checks++;
    if (obs_cyc.size() != 32 || obs_cyc[31] - first_valid + 1 != 63) begin
      errors++;
      $display("FAIL bp_span: got %0d cycles want 63", (obs_cyc.size() == 32) ? obs_cyc[31] - first_valid + 1 : -1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_sched(); ntiles = 2;
    for (int i = 0; i < N1; i++) for (int k = 0; k < N2; k++) begin
      sched[0][i][k] = i + k;
      sched[1][i][k] = i + 4 + k;
    end
    add_exp_tile(0); add_exp_tile(1000);
    run(64, 0, 1'b0, 5, 300);
    checks++; if (obs_q.size() != 64) begin errors++; $display("FAIL b2b_count: got %0d want 64", obs_q.size()); end
    for (int b = 0; b < obs_q.size() && b < exp_q.size(); b++) begin
      checks++;
      if (obs_q[b].data !== exp_q[b].data || obs_q[b].row !== exp_q[b].row ||
          obs_q[b].col !== exp_q[b].col || obs_q[b].last !== exp_q[b].last) begin
        errors++;
        $display("FAIL b2b_beat %0d: got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", b,
                 obs_q[b].data, obs_q[b].row, obs_q[b].col, obs_q[b].last,
                 exp_q[b].data, exp_q[b].row, exp_q[b].col, exp_q[b].last);
      end
    end
    checks++;
    if (obs_cyc.size() < 33 || obs_cyc[32] - obs_cyc[31] != 2) begin
      errors++;
      $display("FAIL b2b_idle_gap: got %0d want 2", (obs_cyc.size() >= 33) ? obs_cyc[32] - obs_cyc[31] : -1);
    end
    checks++; if (ov_end !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", ov_end); end
  endtask

  task automatic test_overflow();
    do_reset(); clear_sched(); ntiles = 3;
    for (int i = 0; i < N1; i++) for (int k = 0; k < N2; k++) begin
      sched[0][i][k] = i + k;
      sched[1][i][k] = i + 4 + k;
      sched[2][i][k] = i + 8 + k;
    end
    add_exp_tile(0); add_exp_tile(1000);
    run(64, 60, 1'b0, 10, 400);
    checks++; if (obs_q.size() != 64) begin errors++; $display("FAIL ovf_count: got %0d want 64", obs_q.size()); end
    for (int b = 0; b < obs_q.size() && b < exp_q.size(); b++) begin
      checks++;
      if (obs_q[b].data !== exp_q[b].data || obs_q[b].row !== exp_q[b].row ||
          obs_q[b].col !== exp_q[b].col || obs_q[b].last !== exp_q[b].last) begin
        errors++;
        $display("FAIL ovf_beat %0d: got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", b,
                 obs_q[b].data, obs_q[b].row, obs_q[b].col, obs_q[b].last,
                 exp_q[b].data, exp_q[b].row, exp_q[b].col, exp_q[b].last);
      end
    end
    checks++; if (stall_q.size() != 48) begin errors++; $display("FAIL ovf_stall_count: got %0d want 48", stall_q.size()); end
    checks++; if (ov_at_ready !== 1'b1) begin errors++; $display("FAIL ovf_flag_before_ready: got %b want 1", ov_at_ready); end
    checks++; if (ov_end !== 1'b1) begin errors++; $display("FAIL ovf_flag_sticky: got %b want 1", ov_end); end
  endtask

  task automatic test_irregular();
    int t, tmax;
    do_reset(); clear_sched(); ntiles = 1; tmax = 0;
    for (int i = 0; i < N1; i++) begin
      t = (i * 3) % 11;
      for (int k = 0; k < N2; k++) begin
        sched[0][i][k] = t;
        if (t > tmax) tmax = t;
        t += 1 + ((i + k) % 3);
      end
    end
    add_exp_tile(0);
    run(32, 0, 1'b0, 5, 300);
    checks++; if (obs_q.size() != 32) begin errors++; $display("FAIL irr_count: got %0d want 32", obs_q.size()); end
    for (int b = 0; b < obs_q.size() && b < exp_q.size(); b++) begin
      checks++;
      if (obs_q[b].data !== exp_q[b].data || obs_q[b].row !== exp_q[b].row ||
          obs_q[b].col !== exp_q[b].col || obs_q[b].last !== exp_q[b].last) begin
        errors++;
        $display("FAIL irr_beat %0d: got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", b,
                 obs_q[b].data, obs_q[b].row, obs_q[b].col, obs_q[b].last,
                 exp_q[b].data, exp_q[b].row, exp_q[b].col, exp_q[b].last);
      end
    end
    checks++; if (first_valid != tmax + 2) begin errors++; $display("FAIL irr_latency: got %0d want %0d", first_valid, tmax + 2); end
    checks++; if (ov_end !== 1'b0) begin errors++; $display("FAIL irr_overflow: got %b want 0", ov_end); end
  endtask

  task automatic test_reset_midstream();
    do_reset(); clear_sched(); ntiles = 1;
    for (int i = 0; i < N1; i++) for (int k = 0; k < N2; k++) sched[0][i][k] = i + k;
    add_exp_tile(0);
    run(10, 0, 1'b0, 0, 200);
    checks++;
    if (obs_q.size() != 10 || obs_q[9].data !== 32'd201) begin
      errors++;
      $display("FAIL rstmid_beat10: got %0d beats, last d=%0d want 10 beats, d=201",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1].data : 32'hffffffff);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_valid  !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid: got %b want 0", m_valid); end
    checks++; if (busy     !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
    rst = 1'b0; m_ready = 1'b0;
    run(32, 0, 1'b0, 5, 200);
    checks++; if (obs_q.size() != 32) begin errors++; $display("FAIL rstmid_fresh_count: got %0d want 32", obs_q.size()); end
    for (int b = 0; b < obs_q.size() && b < exp_q.size(); b++) begin
      checks++;
      if (obs_q[b].data !== exp_q[b].data || obs_q[b].row !== exp_q[b].row ||
          obs_q[b].col !== exp_q[b].col || obs_q[b].last !== exp_q[b].last) begin
        errors++;
        $display("FAIL rstmid_beat %0d: got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", b,
                 obs_q[b].data, obs_q[b].row, obs_q[b].col, obs_q[b].last,
                 exp_q[b].data, exp_q[b].row, exp_q[b].col, exp_q[b].last);
      end
    end
    checks++; if (first_valid != 12) begin errors++; $display("FAIL rstmid_latency: got %0d want 12", first_valid); end
  endtask

  initial begin
    rst = 1'b1; valid_D = '0; D = '0; m_ready = 1'b0;
    test_reset();
    test_single_tile();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_irregular();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
